// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo-N counter.
// Exports count_dir_e, next_mod_t, next_mod() and MAX_COUNTER_WIDTH.
package counter_pkg;

  localparam int MAX_COUNTER_WIDTH = 32;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } count_dir_e;

  typedef struct packed {
    logic                         wrap;
    logic [MAX_COUNTER_WIDTH-1:0] next;
  } next_mod_t;

  // last is MODULUS-1, so a 2**WIDTH modulus
  // never needs a wider operand.
  function automatic next_mod_t next_mod(
    input logic [MAX_COUNTER_WIDTH-1:0] value,
    input logic [MAX_COUNTER_WIDTH-1:0] last,
    input count_dir_e                   up
  );
    next_mod_t r;
    if (up == DIR_UP) begin
      r.wrap = (value == last);
      r.next = r.wrap ? '0 : value + 1'b1;
    end else begin
      r.wrap = (value == '0);
      r.next = r.wrap ? last : value - 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_n_counter_prescaler.sv
// Enable prescaler: tick on every PRESCALE-th enabled cycle.
// Ports: clock, reset_n, clear, enable -> tick.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  // With PRESCALE=1, LAST=0 so every enabled cycle ticks.
  assign tick = enable && !clear && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with load, enable and terminal-count pulse.
// Ports: input_clock, input_reset_n, input_enable, input_up, input_load,
//   input_load_value -> output_count, output_tc, output_zero.
// Macro COUNTER_PRESCALER_EN gates steps through counter_prescaler.
module mod_n_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH       = 4,
  parameter longint unsigned MODULUS     = 10,
  parameter longint unsigned RESET_VALUE = 0,
  parameter int              PRESCALE    = 4
) (
  input  logic             input_clock,
  input  logic             input_reset_n,
  input  logic             input_enable,
  input  logic             input_up,
  input  logic             input_load,
  input  logic [WIDTH-1:0] input_load_value,
  output logic [WIDTH-1:0] output_count,
  output logic             output_tc,
  output logic             output_zero
);

  if (WIDTH < 1 || WIDTH > MAX_COUNTER_WIDTH ||
      MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH) ||
      RESET_VALUE >= MODULUS || PRESCALE < 1) begin : g_bad_param
    $error("mod_n_counter: illegal parameter set");
  end

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] RST  = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             step;
  next_mod_t        nm;
  logic [MAX_COUNTER_WIDTH-1:0] nm_unused;

`ifdef COUNTER_PRESCALER_EN
  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clock  (input_clock),
    .reset_n(input_reset_n),
    .clear  (input_load),
    .enable (input_enable),
    .tick   (step)
  );
`else
  assign step = input_enable;
`endif

  assign nm = next_mod(MAX_COUNTER_WIDTH'(count_q),
                       MAX_COUNTER_WIDTH'(LAST),
                       count_dir_e'(input_up));
  assign nm_unused = nm.next;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (input_load) begin
      count_d = (input_load_value > LAST) ? LAST
                                          : input_load_value;
    end else if (step) begin
      count_d = nm.next[WIDTH-1:0];
      tc_d    = nm.wrap;
    end
  end

  always_ff @(posedge input_clock or negedge input_reset_n) begin
    if (!input_reset_n) begin
      count_q <= RST;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign output_count = count_q;
  assign output_tc    = tc_q;
  assign output_zero  = (count_q == '0);

endmodule

// File: tb/tb_mod_n_counter.sv
// Self-checking bench for mod_n_counter (WIDTH=4, MODULUS=10).
// Reference model is plain modular arithmetic on integers.
module tb_mod_n_counter;

  localparam int W  = 4;
  localparam int M  = 10;
  localparam int RV = 0;
`ifdef COUNTER_PRESCALER_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic         up;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         tc;
  logic         zero;

  int vectors = 0;
  int miscompares = 0;

  int m_cnt = RV;
  int m_psc = 0;
  int m_tc  = 0;

  mod_n_counter #(
    .WIDTH      (W),
    .MODULUS    (M),
    .RESET_VALUE(RV),
    .PRESCALE   (4)
  ) dut (
    .input_clock     (clk),
    .input_reset_n   (rst_n),
    .input_enable    (enable),
    .input_up        (up),
    .input_load      (load),
    .input_load_value(load_value),
    .output_count    (count),
    .output_tc       (tc),
    .output_zero     (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string tag, int obs, int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".count"}, int'(count), m_cnt);
    chk({tag, ".tc"}, int'(tc), m_tc);
    chk({tag, ".zero"}, int'(zero), int'(m_cnt == 0));
  endtask

  task automatic model_reset();
    m_cnt = RV;
    m_psc = 0;
    m_tc  = 0;
  endtask

  task automatic model_edge(bit en, bit u, bit ld, int val);
    if (ld) begin
      m_cnt = (val >= M) ? M - 1 : val;
      m_psc = 0;
      m_tc  = 0;
    end else if (en && m_psc == PS - 1) begin
      m_psc = 0;
      if (u) begin
        m_tc  = int'(m_cnt == M - 1);
        m_cnt = (m_cnt + 1) % M;
      end else begin
        m_tc  = int'(m_cnt == 0);
        m_cnt = (m_cnt + M - 1) % M;
      end
    end else begin
      if (en) m_psc++;
      m_tc = 0;
    end
  endtask

  task automatic cyc(string tag, bit en, bit u, bit ld, int val);
    enable     = en;
    up         = u;
    load       = ld;
    load_value = W'(val);
    @(posedge clk);
    model_edge(en, u, ld, val);
    #1;
    chk_all(tag);
  endtask

  task automatic async_reset(string tag);
    @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk_all(tag);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    up         = 1'b1;
    load       = 1'b0;
    load_value = '0;

    #12;
    chk_all("reset");
    chk("reset.const", int'(count), RV);
    rst_n = 1'b1;

    for (int i = 0; i < 12 * PS; i++) cyc("up", 1, 1, 0, 0);

    async_reset("rst_down");
    for (int i = 0; i < 4 * PS; i++) cyc("down", 1, 0, 0, 0);

    cyc("ld4", 0, 1, 1, 4);
    cyc("ld13", 1, 1, 1, 13);
    chk("clamp.const", int'(count), M - 1);
    chk("clamp.tc", int'(tc), 0);
    for (int i = 0; i < PS; i++) cyc("wrap_after_ld", 1, 1, 0, 0);

    cyc("ld9", 0, 1, 1, 9);
    for (int i = 0; i < 5; i++) cyc("hold", 0, 1, 0, 0);
    for (int i = 0; i < PS; i++) cyc("reverse", 1, 0, 0, 0);

    cyc("ld7", 0, 1, 1, 7);
    async_reset("rst_mid");
    for (int i = 0; i < 3 * PS; i++) cyc("resume", 1, 1, 0, 0);

    cyc("ps.e1", 1, 1, 0, 0);
    cyc("ps.e1", 1, 1, 0, 0);
    cyc("ps.e0", 0, 1, 0, 0);
    cyc("ps.e1", 1, 1, 0, 0);
    cyc("ps.e1", 1, 1, 0, 0);
    cyc("ps.e1", 1, 1, 0, 0);
    cyc("ps.ld", 1, 1, 1, 2);
    for (int i = 0; i < 4; i++) cyc("ps.after_ld", 1, 1, 0, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset("rnd_rst");
      end else begin
        cyc("rnd",
            ($urandom_range(0, 3) != 0),
            $urandom_range(0, 1) == 1,
            ($urandom_range(0, 11) == 0),
            int'($urandom_range(0, 15)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
